// File: rtl/uba_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uba_intr_ctrl
// Brief   : UBA interrupt controller. Maps device BR lines to KS10 PI requests,
//           arbitrates interrupt-acknowledge cycles and returns the device vector.
//           Optional macro UBA_INTR_SYNC_EN adds 2-flop input synchronizers.
// Revision: 1.0 - initial release
// ============================================================================
module uba_intr_ctrl #(
  parameter logic [3:0]  UBANUM     = 4'd1,
  parameter int unsigned TMO_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:5][7:4] devINTR,
  input  logic [0:2]      statPIH,
  input  logic [0:2]      statPIL,
  input  logic            busACKI,
  input  logic [0:2]      busACKLEV,
  output logic [1:7]      busPI,
  output logic [1:5][7:4] devIACK,
  input  logic            devVECTV,
  input  logic [15:0]     devVECT,
  output logic            busVECTV,
  output logic [0:35]     busVECT,
  output logic            setTMO
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARB  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

  logic [1:5][7:4] dev_intr;
  logic            vectv_in;
  logic [15:0]     vect_in;

`ifdef UBA_INTR_SYNC_EN
  logic [1:5][7:4] intr_m_q, intr_s_q;
  logic            vectv_m_q, vectv_s_q;
  logic [15:0]     vect_m_q, vect_s_q;

  // Vector data is staged alongside its valid so both arrive together.
  always_ff @(posedge clk) begin
    if (rst) begin
      intr_m_q  <= '0;
      intr_s_q  <= '0;
      vectv_m_q <= 1'b0;
      vectv_s_q <= 1'b0;
      vect_m_q  <= '0;
      vect_s_q  <= '0;
    end else begin
      intr_m_q  <= devINTR;
      intr_s_q  <= intr_m_q;
      vectv_m_q <= devVECTV;
      vectv_s_q <= vectv_m_q;
      vect_m_q  <= devVECT;
      vect_s_q  <= vect_m_q;
    end
  end

  assign dev_intr = intr_s_q;
  assign vectv_in = vectv_s_q;
  assign vect_in  = vect_s_q;
`else
  assign dev_intr = devINTR;
  assign vectv_in = devVECTV;
  assign vect_in  = devVECT;
`endif

  logic [1:0]      state_q, state_d;
  logic [2:0]      lev_q, lev_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:5][7:4] iack_q, iack_d;
  logic            vectv_q;
  logic [15:0]     vect_q;
  logic [0:35]     busVECT_q, busVECT_d;
  logic            busVECTV_q, busVECTV_d;
  logic            setTMO_q, setTMO_d;
  logic [1:7]      busPI_q, busPI_d;

  logic            int_hi, int_lo;
  logic            hi_match, lo_match;
  logic            win_found;
  logic [1:5][7:4] win_grant;

  always_comb begin
    int_hi = 1'b0;
    int_lo = 1'b0;
    for (int d = 1; d <= 5; d++) begin
      int_hi = int_hi | dev_intr[d][7] | dev_intr[d][6];
      int_lo = int_lo | dev_intr[d][5] | dev_intr[d][4];
    end
  end

  // An assignment of 0 never matches any level, which disables that group.
  always_comb begin
    busPI_d = '0;
    for (int n = 1; n <= 7; n++) begin
      busPI_d[n] = ((statPIH == 3'(n)) & int_hi) | ((statPIL == 3'(n)) & int_lo);
    end
  end

  always_comb begin
    hi_match  = (statPIH != 3'd0) && (statPIH == lev_q) && int_hi;
    lo_match  = (statPIL != 3'd0) && (statPIL == lev_q) && int_lo;
    win_found = 1'b0;
    win_grant = '0;
    // Outer loop over BR gives priority to the higher request; inner loop to the lower device.
    for (int b = 7; b >= 4; b--) begin
      for (int d = 1; d <= 5; d++) begin
        if (!win_found && dev_intr[d][b] &&
            ((hi_match && b >= 6) || (!hi_match && lo_match && b <= 5))) begin
          win_grant[d][b] = 1'b1;
          win_found       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lev_d      = lev_q;
    cnt_d      = cnt_q;
    iack_d     = iack_q;
    busVECT_d  = busVECT_q;
    busVECTV_d = 1'b0;
    setTMO_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (busACKI) begin
          lev_d   = busACKLEV;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        cnt_d = '0;
        if (win_found) begin
          iack_d  = win_grant;
          state_d = S_WAIT;
        end else begin
          busVECT_d  = '0;
          busVECTV_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_WAIT: begin
        if (vectv_q) begin
          busVECT_d  = {14'b0, UBANUM, 2'b0, vect_q};
          iack_d     = '0;
          busVECTV_d = 1'b1;
          state_d    = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          busVECT_d  = '0;
          iack_d     = '0;
          setTMO_d   = 1'b1;
          busVECTV_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lev_q      <= '0;
      cnt_q      <= '0;
      iack_q     <= '0;
      vectv_q    <= 1'b0;
      vect_q     <= '0;
      busVECT_q  <= '0;
      busVECTV_q <= 1'b0;
      setTMO_q   <= 1'b0;
      busPI_q    <= '0;
    end else begin
      state_q    <= state_d;
      lev_q      <= lev_d;
      cnt_q      <= cnt_d;
      iack_q     <= iack_d;
      vectv_q    <= vectv_in;
      vect_q     <= vect_in;
      busVECT_q  <= busVECT_d;
      busVECTV_q <= busVECTV_d;
      setTMO_q   <= setTMO_d;
      busPI_q    <= busPI_d;
    end
  end

  assign busPI    = busPI_q;
  assign devIACK  = iack_q;
  assign busVECTV = busVECTV_q;
  assign busVECT  = busVECT_q;
  assign setTMO   = setTMO_q;

endmodule
`default_nettype wire

// File: tb/tb_uba_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uba_intr_ctrl
// Brief   : Randomized self-checking bench for uba_intr_ctrl against a
//           transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uba_intr_ctrl;

  localparam logic [3:0] UBANUM = 4'd5;
  localparam int         TMO    = 64;
`ifdef UBA_INTR_SYNC_EN
  localparam int PI_LAT = 3;
  localparam int VX     = 2;
`else
  localparam int PI_LAT = 1;
  localparam int VX     = 0;
`endif

  logic            clk;
  logic            rst;
  logic [1:5][7:4] devINTR;
  logic [0:2]      statPIH;
  logic [0:2]      statPIL;
  logic            busACKI;
  logic [0:2]      busACKLEV;
  logic [1:7]      busPI;
  logic [1:5][7:4] devIACK;
  logic            devVECTV;
  logic [15:0]     devVECT;
  logic            busVECTV;
  logic [0:35]     busVECT;
  logic            setTMO;

  int n_checks = 0;
  int n_errors = 0;

  uba_intr_ctrl #(.UBANUM(UBANUM), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .devINTR(devINTR), .statPIH(statPIH), .statPIL(statPIL),
    .busACKI(busACKI), .busACKLEV(busACKLEV), .busPI(busPI), .devIACK(devIACK),
    .devVECTV(devVECTV), .devVECT(devVECT), .busVECTV(busVECTV), .busVECT(busVECT),
    .setTMO(setTMO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:7] model_pi(input logic [1:5][7:4] intr,
                                          input logic [2:0] pih, input logic [2:0] pil);
    logic [1:7] pi;
    bit hi, lo;
    pi = '0; hi = 0; lo = 0;
    for (int d = 1; d <= 5; d++) begin
      if (intr[d][7] || intr[d][6]) hi = 1;
      if (intr[d][5] || intr[d][4]) lo = 1;
    end
    if (pih != 0 && hi) pi[pih] = 1'b1;
    if (pil != 0 && lo) pi[pil] = 1'b1;
    return pi;
  endfunction

  function automatic logic [1:5][7:4] model_grant(input logic [1:5][7:4] intr,
      input logic [2:0] pih, input logic [2:0] pil, input logic [2:0] lev);
    logic [1:5][7:4] g;
    int best, bd, bb, lo_b, hi_b;
    bit hi, lo;
    g = '0; best = -1; bd = 1; bb = 4; hi = 0; lo = 0;
    for (int d = 1; d <= 5; d++) begin
      if (intr[d][7] || intr[d][6]) hi = 1;
      if (intr[d][5] || intr[d][4]) lo = 1;
    end
    if (pih != 0 && pih == lev && hi) begin lo_b = 6; hi_b = 7; end
    else if (pil != 0 && pil == lev && lo) begin lo_b = 4; hi_b = 5; end
    else return g;
    for (int d = 1; d <= 5; d++)
      for (int b = lo_b; b <= hi_b; b++)
        if (intr[d][b] && (b * 10 - d) > best) begin
          best = b * 10 - d; bd = d; bb = b;
        end
    g[bd][bb] = 1'b1;
    return g;
  endfunction

  // resp < 0 means the device never answers.
  task automatic do_ack(input logic [2:0] lev, input int resp, input logic [15:0] vec,
                        input bit drop, input bit noise);
    logic [1:5][7:4] eg;
    logic [0:35]     ev;
    bit              passive, use_vec, tmo;
    int              endc;
    eg      = model_grant(devINTR, statPIH, statPIL, lev);
    passive = (eg == '0);
    use_vec = !passive && resp >= 0 && (resp + 2 + VX) <= TMO;
    if (passive) begin
      endc = 2; ev = '0; tmo = 0;
    end else if (use_vec) begin
      endc = 4 + resp + VX; ev = {14'b0, UBANUM, 2'b0, vec}; tmo = 0;
    end else begin
      endc = 2 + TMO; ev = '0; tmo = 1;
    end
    busACKI = 1'b1; busACKLEV = lev;
    tick();
    busACKI = 1'b0;
    for (int c = 1; c <= endc; c++) begin
      devVECTV = !passive && resp >= 0 && c == 2 + resp;
      devVECT  = vec;
      busACKI  = noise && !passive && c == 3;
      if (drop && c == 3) devINTR = '0;
      check("iack", devIACK, (!passive && c >= 2 && c < endc) ? eg : '0);
      check("vectv", busVECTV, c == endc);
      check("settmo", setTMO, tmo && c == endc);
      if (c == endc) check("vect", busVECT, ev);
      tick();
    end
    devVECTV = 1'b0; busACKI = 1'b0;
    check("vectv_after", busVECTV, 0);
    check("settmo_after", setTMO, 0);
  endtask

  task automatic set_inputs(input logic [1:5][7:4] intr, input logic [2:0] pih, input logic [2:0] pil);
    devINTR = intr; statPIH = pih; statPIL = pil;
    repeat (PI_LAT) tick();
    check("busPI", busPI, model_pi(intr, pih, pil));
  endtask

  initial begin
    logic [1:5][7:4] iv;
    logic [2:0]      pih, pil, lev;
    int              r, resp;

    rst = 1'b1; devINTR = '0; statPIH = '0; statPIL = '0; busACKI = 1'b0;
    busACKLEV = '0; devVECTV = 1'b0; devVECT = '0;
    repeat (3) tick();
    check("rst_busPI", busPI, 0);
    check("rst_iack", devIACK, 0);
    check("rst_vectv", busVECTV, 0);
    check("rst_vect", busVECT, 0);
    check("rst_tmo", setTMO, 0);
    rst = 1'b0;
    tick();

    // Device 2 BR5 on PIL=3.
    devINTR = '0; devINTR[2][5] = 1'b1; statPIL = 3'd3; statPIH = 3'd0;
    repeat (PI_LAT) tick();
    check("pi_dev2_br5", busPI, 7'b0010000);
    check("pi_iack0", devIACK, 0);
    check("pi_vectv0", busVECTV, 0);
    check("pi_tmo0", setTMO, 0);

    // BR7 on dev4 beats BR6 on dev1 at PIH=5.
    iv = '0; iv[4][7] = 1'b1; iv[1][6] = 1'b1;
    set_inputs(iv, 3'd5, 3'd0);
    do_ack(3'd5, 1, 16'o270, 0, 0);

    // BR4 tie between dev3 and dev5 breaks to dev3.
    iv = '0; iv[3][4] = 1'b1; iv[5][4] = 1'b1;
    set_inputs(iv, 3'd0, 3'd2);
    do_ack(3'd2, 3, 16'o1234, 0, 0);

    do_ack(3'd2, -1, 16'h0, 0, 0);
    do_ack(3'd2, TMO - 2 - VX, 16'hBEEF, 0, 0);
    do_ack(3'd2, TMO - 1 - VX, 16'hCAFE, 0, 0);

    // No assignment at level 6: passive release.
    iv = '0; iv[1][7] = 1'b1; iv[2][4] = 1'b1;
    set_inputs(iv, 3'd1, 3'd2);
    do_ack(3'd6, 0, 16'h0, 0, 0);

    // Reset while waiting for a vector.
    iv = '0; iv[1][7] = 1'b1;
    set_inputs(iv, 3'd4, 3'd0);
    busACKI = 1'b1; busACKLEV = 3'd4;
    tick();
    busACKI = 1'b0;
    tick(); tick();
    check("wait_iack", devIACK, model_grant(devINTR, statPIH, statPIL, 3'd4));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_iack", devIACK, 0);
    check("rstw_vectv", busVECTV, 0);
    check("rstw_tmo", setTMO, 0);
    check("rstw_busPI", busPI, 0);
    devVECTV = 1'b1; devVECT = 16'o777;
    tick();
    devVECTV = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("rstw_no_vectv", busVECTV, 0);
      check("rstw_no_iack", devIACK, 0);
      check("rstw_no_tmo", setTMO, 0);
      tick();
    end

    for (int t = 0; t < 40; t++) begin
      for (int d = 1; d <= 5; d++)
        for (int b = 4; b <= 7; b++)
          iv[d][b] = ($urandom_range(0, 3) == 0);
      pih = 3'($urandom_range(0, 7));
      pil = 3'($urandom_range(0, 7));
      set_inputs(iv, pih, pil);
      r = $urandom_range(0, 3);
      lev = (r == 0) ? pil : (r == 3) ? 3'($urandom_range(1, 7)) : pih;
      r = $urandom_range(0, 9);
      resp = (r == 0) ? -1 : (r == 1) ? (TMO - 2 - VX) : $urandom_range(0, 10);
      do_ack(lev, resp, 16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
